// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the execute stage.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign-fixed at completion.
module muldiv_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          MUL_FAST = 1'b0,
    parameter int unsigned CNT_W    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcAE,
    input  logic [WIDTH-1:0] srcBE,
    input  logic             cancelE,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divZero
);
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_hi, r_lo, r_acc, r_q, r_m;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy, r_done, r_div_zero, r_neg_q, r_neg_r;

    logic             w_idle, w_run, w_accept, w_is_div, w_signed;
    logic             w_sign_a, w_sign_b, w_div0, w_one;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_acc_nxt, w_q_nxt, w_res_hi, w_res_lo;
    logic [W2-1:0]    w_fast_prod, w_fast_fix, w_prod, w_prod_fix;
    logic [WIDTH:0]   w_sum, w_shift, w_trial;

    // FIX is the completion cycle; it accepts work exactly like IDLE
    assign w_idle   = (r_state == IDLE) || (r_state == FIX);
    assign w_run    = (r_state == MUL) || (r_state == DIV);
    assign w_accept = w_idle & startE & ~cancelE;
    assign w_is_div = opE[1];
    assign w_signed = ~opE[0];
    assign w_sign_a = w_signed & srcAE[WIDTH-1];
    assign w_sign_b = w_signed & srcBE[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -srcAE : srcAE;
    assign w_mag_b  = w_sign_b ? -srcBE : srcBE;
    assign w_div0   = w_is_div & (srcBE == '0);
    assign w_one    = w_div0 | (~w_is_div & MUL_FAST);

    assign w_fast_prod = W2'(w_mag_a) * W2'(w_mag_b);
    assign w_fast_fix  = (w_sign_a ^ w_sign_b) ? -w_fast_prod : w_fast_prod;

    // One iteration step: shift-add for multiply, restoring subtract for divide
    assign w_sum   = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_m : '0)};
    assign w_shift = {r_acc, r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_m};

    always_comb begin
        w_acc_nxt = w_sum[WIDTH:1];
        w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
        if (r_state == DIV) begin
            if (!w_trial[WIDTH]) begin
                w_acc_nxt = w_trial[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_shift[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign w_prod     = {w_acc_nxt, w_q_nxt};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_res_hi   = (r_state == DIV) ? (r_neg_r ? -w_acc_nxt : w_acc_nxt) : w_prod_fix[W2-1:WIDTH];
    assign w_res_lo   = (r_state == DIV) ? (r_neg_q ? -w_q_nxt : w_q_nxt) : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, FIX: begin
                w_state_nxt = IDLE;
                if (w_accept) begin
                    if (w_one)         w_state_nxt = FIX;
                    else if (w_is_div) w_state_nxt = DIV;
                    else               w_state_nxt = MUL;
                end
            end
            MUL, DIV: begin
                if (cancelE)             w_state_nxt = IDLE;
                else if (r_cnt == '0)    w_state_nxt = FIX;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_m        <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            if (w_idle) begin
                if (hiWrite) r_hi <= wdata;
                if (loWrite) r_lo <= wdata;
            end
            if (w_accept) begin
                r_neg_q <= w_sign_a ^ w_sign_b;
                r_neg_r <= w_sign_a;
                r_cnt   <= CNT_W'(WIDTH - 1);
                r_acc   <= '0;
                r_q     <= w_is_div ? w_mag_a : w_mag_b;
                r_m     <= w_is_div ? w_mag_b : w_mag_a;
                r_busy  <= ~w_one;
                if (w_one) begin
                    r_done     <= 1'b1;
                    r_div_zero <= w_div0;
                    r_hi       <= w_div0 ? srcAE : w_fast_fix[W2-1:WIDTH];
                    r_lo       <= w_div0 ? '1 : w_fast_fix[WIDTH-1:0];
                end
            end
            if (w_run) begin
                if (cancelE) begin
                    r_busy <= 1'b0;
                end else begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // last step lands the corrected result so it is visible with done
                    if (r_cnt == '0) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                    end
                end
            end
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign busy    = r_busy;
    assign done    = r_done;
    assign divZero = r_div_zero;
endmodule
